pcie_rq_tag_mgr: RTL and testbench

Allocates, tracks and retires PCIe non-posted request tags for the RQ path in the pcie_clk domain. The RQ request builder takes a tag from this block before issuing a read. The RC completion parser returns the tag on the last completion of that read. A background scanner ages outstanding tags against a programmable timeout and either reports expired tags or reclaims them.

---
 rtl/pcie_rq_tag_mgr_pkg.sv | 14 +
 rtl/pcie_rq_tag_mgr_rr_find.sv | 30 +++
 rtl/pcie_rq_tag_mgr.sv | 157 +++++++++++++++
 tb/tb_pcie_rq_tag_mgr.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_rq_tag_mgr_pkg.sv
// Shared types and constants for the PCIe RQ tag manager.
package pcie_tag_pkg;

  localparam logic [15:0] TOUT_DISABLE = 16'h0;

  function automatic int tag_w(input int maxtag);
    return $clog2(maxtag);
  endfunction

  // Wide enough for the largest legal tag space (64 tags).
  typedef logic [5:0]  tag_t;
  typedef logic [15:0] ts_t;

endpackage

// File: rtl/pcie_rq_tag_mgr_rr_find.sv
// Combinational rotating-priority finder: first set bit of free_vec at or after start, wrapping.
module pcie_tag_rr_find
  import pcie_tag_pkg::*;
#(
  parameter int MAXTAG = 32,
  localparam int TAGW  = tag_w(MAXTAG)
) (
  input  logic [MAXTAG-1:0] free_vec,
  input  logic [TAGW-1:0]   start,
  output logic              found,
  output logic [TAGW-1:0]   idx
);

  logic [TAGW-1:0] pos;

  // Walk from the farthest offset down so the nearest hit to start is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = MAXTAG - 1; i >= 0; i--) begin
      pos = start + TAGW'(i);
      if (free_vec[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/pcie_rq_tag_mgr.sv
// PCIe RQ non-posted tag allocator with release tracking and timeout scanner.
// Optional statistics counters are built when TAG_MGR_STAT_EN is defined.
module pcie_rq_tag_mgr
  import pcie_tag_pkg::*;
#(
  parameter int MAXTAG   = 32,
  parameter int TS_W     = 16,
  parameter int TICK_DIV = 256,
  localparam int TAGW    = tag_w(MAXTAG)
) (
  input  logic            pcie_clk,
  input  logic            pcie_rst,
  input  logic            tag_en,
  input  logic            tag_recovery,
  input  logic [15:0]     tag_tout_set,
  output logic            alloc_valid,
  input  logic            alloc_ready,
  output logic [TAGW-1:0] alloc_tag,
  input  logic            rel_valid,
  input  logic [TAGW-1:0] rel_tag,
  output logic            tout_valid,
  output logic [TAGW-1:0] tout_tag,
  output logic            spur_valid,
  output logic [TAGW-1:0] spur_tag,
  output logic [TAGW:0]   busy_cnt,
  output logic            all_idle,
  output logic [31:0]     stat_tout_cnt,
  output logic [31:0]     stat_spur_cnt
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [TAGW-1:0]    TAG_ONE    = TAGW'(1);
  localparam logic [TAGW:0]      CNT_ONE    = (TAGW+1)'(1);

  logic [MAXTAG-1:0]  busy;
  logic [MAXTAG-1:0]  timed_out;
  logic [TS_W-1:0]    stamp [MAXTAG];
  logic [TAGW-1:0]    search_ptr;
  logic [TAGW-1:0]    scan_ptr;
  logic [PRESC_W-1:0] presc;
  logic [TS_W-1:0]    tick_cnt;

  logic               found;
  logic [TAGW-1:0]    found_idx;
  logic               hs;
  logic               rel_hit;
  logic               rel_spur;
  logic [TS_W-1:0]    age;
  logic               expire;
  logic               reclaim;
  logic [TAGW:0]      cnt_nxt;

  pcie_tag_rr_find #(.MAXTAG(MAXTAG)) u_find (
    .free_vec (~busy),
    .start    (search_ptr),
    .found    (found),
    .idx      (found_idx)
  );

  // A release on the tag under scan always beats its expiry.
  always_comb begin
    hs       = alloc_valid & alloc_ready;
    rel_hit  = rel_valid & busy[rel_tag];
    rel_spur = rel_valid & ~busy[rel_tag];
    age      = tick_cnt - stamp[scan_ptr];
    expire   = busy[scan_ptr] & ~timed_out[scan_ptr]
             & (tag_tout_set != TOUT_DISABLE)
             & (32'(age) > 32'(tag_tout_set))
             & ~(rel_valid & (rel_tag == scan_ptr));
    reclaim  = expire & tag_recovery;
    cnt_nxt  = busy_cnt;
    if (hs)      cnt_nxt = cnt_nxt + CNT_ONE;
    if (rel_hit) cnt_nxt = cnt_nxt - CNT_ONE;
    if (reclaim) cnt_nxt = cnt_nxt - CNT_ONE;
  end

  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) begin
      busy        <= '0;
      timed_out   <= '0;
      search_ptr  <= '0;
      scan_ptr    <= '0;
      presc       <= '0;
      tick_cnt    <= '0;
      alloc_valid <= 1'b0;
      alloc_tag   <= '0;
      tout_valid  <= 1'b0;
      spur_valid  <= 1'b0;
      busy_cnt    <= '0;
    end else begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + PRESC_W'(1);
      if (presc == PRESC_LAST) tick_cnt <= tick_cnt + TS_W'(1);
      scan_ptr <= scan_ptr + TAG_ONE;

      // Offer is dropped for one cycle after a handshake so the search sees the updated bitmap.
      if (hs) begin
        alloc_valid     <= 1'b0;
        busy[alloc_tag] <= 1'b1;
        search_ptr      <= alloc_tag + TAG_ONE;
      end else if (!tag_en) begin
        alloc_valid <= 1'b0;
      end else if (!alloc_valid) begin
        alloc_valid <= found;
        if (found) alloc_tag <= found_idx;
      end

      if (rel_hit) begin
        busy[rel_tag]      <= 1'b0;
        timed_out[rel_tag] <= 1'b0;
      end

      if (expire) begin
        if (tag_recovery) busy[scan_ptr]      <= 1'b0;
        else              timed_out[scan_ptr] <= 1'b1;
      end

      tout_valid <= expire;
      spur_valid <= rel_spur;
      busy_cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge pcie_clk) begin
    if (hs)       stamp[alloc_tag] <= tick_cnt;
    if (expire)   tout_tag         <= scan_ptr;
    if (rel_spur) spur_tag         <= rel_tag;
  end

  assign all_idle = (busy_cnt == '0);

`ifdef TAG_MGR_STAT_EN
  logic [31:0] tout_total;
  logic [31:0] spur_total;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) begin
      tout_total <= '0;
      spur_total <= '0;
    end else begin
      if (tout_valid) tout_total <= sat_inc(tout_total);
      if (spur_valid) spur_total <= sat_inc(spur_total);
    end
  end

  assign stat_tout_cnt = tout_total;
  assign stat_spur_cnt = spur_total;
`else
  assign stat_tout_cnt = '0;
  assign stat_spur_cnt = '0;
`endif

endmodule

// File: tb/tb_pcie_rq_tag_mgr.sv
// Directed self-checking bench for pcie_rq_tag_mgr (MAXTAG=32, TICK_DIV=256).
module tb_pcie_rq_tag_mgr;

  localparam int TAGW = 5;

  logic            pcie_clk = 1'b0;
  logic            pcie_rst = 1'b1;
  logic            tag_en = 1'b1;
  logic            tag_recovery = 1'b1;
  logic [15:0]     tag_tout_set = 16'h0;
  logic            alloc_valid;
  logic            alloc_ready = 1'b0;
  logic [TAGW-1:0] alloc_tag;
  logic            rel_valid = 1'b0;
  logic [TAGW-1:0] rel_tag = '0;
  logic            tout_valid;
  logic [TAGW-1:0] tout_tag;
  logic            spur_valid;
  logic [TAGW-1:0] spur_tag;
  logic [TAGW:0]   busy_cnt;
  logic            all_idle;
  logic [31:0]     stat_tout_cnt;
  logic [31:0]     stat_spur_cnt;

  int checks = 0;
  int failures = 0;
  int cyc;

  pcie_rq_tag_mgr dut (
    .pcie_clk      (pcie_clk),
    .pcie_rst      (pcie_rst),
    .tag_en        (tag_en),
    .tag_recovery  (tag_recovery),
    .tag_tout_set  (tag_tout_set),
    .alloc_valid   (alloc_valid),
    .alloc_ready   (alloc_ready),
    .alloc_tag     (alloc_tag),
    .rel_valid     (rel_valid),
    .rel_tag       (rel_tag),
    .tout_valid    (tout_valid),
    .tout_tag      (tout_tag),
    .spur_valid    (spur_valid),
    .spur_tag      (spur_tag),
    .busy_cnt      (busy_cnt),
    .all_idle      (all_idle),
    .stat_tout_cnt (stat_tout_cnt),
    .stat_spur_cnt (stat_spur_cnt)
  );

  always #5 pcie_clk = ~pcie_clk;

  // Edges since reset release; equals the scanner position modulo 32.
  always @(posedge pcie_clk or posedge pcie_rst)
    if (pcie_rst) cyc <= 0;
    else          cyc <= cyc + 1;

  task automatic step();
    @(posedge pcie_clk);
    @(negedge pcie_clk);
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic do_reset();
    pcie_rst    = 1'b1;
    rel_valid   = 1'b0;
    alloc_ready = 1'b0;
    step();
    step();
    pcie_rst = 1'b0;
  endtask

  task automatic do_alloc(output logic [TAGW-1:0] t);
    for (int n = 0; n < 8 && !alloc_valid; n++) step();
    chk("alloc_offer", alloc_valid, 1'b1);
    t = alloc_tag;
    alloc_ready = 1'b1;
    step();
    alloc_ready = 1'b0;
  endtask

  task automatic do_release(input logic [TAGW-1:0] t);
    rel_valid = 1'b1;
    rel_tag   = t;
    step();
    rel_valid = 1'b0;
  endtask

  logic [TAGW-1:0] t;
  int              elapsed;
  int              start;
  int              tcount;
  logic [TAGW-1:0] ttag;

  initial begin
    // Reset state
    @(negedge pcie_clk);
    chk("rst_alloc_valid", alloc_valid, 1'b0);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_busy_cnt", busy_cnt, 0);
    chk("rst_all_idle", all_idle, 1'b1);
    chk("rst_tout_valid", tout_valid, 1'b0);
    chk("rst_spur_valid", spur_valid, 1'b0);
    chk("rst_stat_tout", stat_tout_cnt, 0);
    chk("rst_stat_spur", stat_spur_cnt, 0);
    do_reset();

    // Allocate every tag in order
    for (int i = 0; i < 32; i++) begin
      do_alloc(t);
      chk("alloc_order", t, i);
    end
    step();
    step();
    chk("full_alloc_valid", alloc_valid, 1'b0);
    chk("full_busy_cnt", busy_cnt, 32);
    chk("full_all_idle", all_idle, 1'b0);

    // Release 5 while full: reoffered two cycles later
    do_release(5);
    step();
    chk("reoffer_valid", alloc_valid, 1'b1);
    chk("reoffer_tag", alloc_tag, 5);
    chk("reoffer_busy_cnt", busy_cnt, 31);
    do_alloc(t);
    chk("realloc_tag", t, 5);
    chk("realloc_busy_cnt", busy_cnt, 32);

    // Free 7, hold its offer, then release it again: spurious
    do_release(7);
    step();
    chk("offer7_tag", alloc_tag, 7);
    chk("offer7_busy_cnt", busy_cnt, 31);
    rel_valid = 1'b1;
    rel_tag   = 7;
    step();
    rel_valid = 1'b0;
    chk("spur7_valid", spur_valid, 1'b1);
    chk("spur7_tag", spur_tag, 7);
    step();
    chk("spur7_pulse", spur_valid, 1'b0);
    chk("spur7_busy_cnt", busy_cnt, 31);
    chk("hold_valid", alloc_valid, 1'b1);
    chk("hold_tag", alloc_tag, 7);
`ifdef TAG_MGR_STAT_EN
    chk("stat_spur_1", stat_spur_cnt, 1);
`else
    chk("stat_spur_tied", stat_spur_cnt, 0);
`endif

    // Timeout with recovery; mid-operation reset first
    tag_tout_set = 16'd2;
    tag_recovery = 1'b1;
    do_reset();
    chk("midrst_busy_cnt", busy_cnt, 0);
    do_release(3);
    chk("late_rel_spur", spur_valid, 1'b1);
    chk("late_rel_tag", spur_tag, 3);
    do_alloc(t);
    chk("tout_alloc_tag", t, 0);
    start = cyc;
    for (int n = 0; n < 1400 && !tout_valid; n++) step();
    elapsed = cyc - start;
    chk("tout_seen", tout_valid, 1'b1);
    chk("tout_tag", tout_tag, 0);
    chk("tout_window", (elapsed > 600 && elapsed < 1200), 1'b1);
    chk("tout_reclaim_cnt", busy_cnt, 0);
    step();
    chk("tout_pulse", tout_valid, 1'b0);
    do_release(0);
    chk("reclaimed_rel_spur", spur_valid, 1'b1);
    chk("reclaimed_rel_tag", spur_tag, 0);
    step();
`ifdef TAG_MGR_STAT_EN
    chk("stat_tout_1", stat_tout_cnt, 1);
    chk("stat_spur_2", stat_spur_cnt, 2);
`else
    chk("stat_tout_tied", stat_tout_cnt, 0);
    chk("stat_spur_tied2", stat_spur_cnt, 0);
`endif

    // Timeout without recovery: single report, tag stays busy
    tag_recovery = 1'b0;
    do_reset();
    do_alloc(t);
    chk("norec_alloc_tag", t, 0);
    tcount = 0;
    ttag   = '1;
    for (int n = 0; n < 20 * 256; n++) begin
      step();
      if (tout_valid) begin
        tcount++;
        ttag = tout_tag;
      end
    end
    chk("norec_tout_count", tcount, 1);
    chk("norec_tout_tag", ttag, 0);
    chk("norec_busy_cnt", busy_cnt, 1);
    do_release(0);
    chk("norec_rel_no_spur", spur_valid, 1'b0);
    chk("norec_rel_busy_cnt", busy_cnt, 0);
    chk("norec_held_tag", alloc_tag, 1);
    tag_tout_set = 16'd0;
    for (int i = 1; i < 32; i++) begin
      do_alloc(t);
      chk("norec_cycle_tag", t, i);
    end
    step();
    chk("norec_reoffer_valid", alloc_valid, 1'b1);
    chk("norec_reoffer_tag", alloc_tag, 0);

    // Release and expiry of tag 3 in the same cycle
    tag_recovery = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) do_alloc(t);
    chk("race_last_tag", t, 3);
    do_release(0);
    do_release(1);
    do_release(2);
    chk("race_busy_cnt_pre", busy_cnt, 1);
    for (int n = 0; n < 2000 && !(cyc >= 700 && (cyc % 32) == 3); n++) step();
    chk("race_aligned", (cyc % 32), 3);
    tag_tout_set = 16'd1;
    rel_valid    = 1'b1;
    rel_tag      = 3;
    step();
    rel_valid    = 1'b0;
    tag_tout_set = 16'd0;
    chk("race_no_tout", tout_valid, 1'b0);
    chk("race_no_spur", spur_valid, 1'b0);
    chk("race_busy_cnt", busy_cnt, 0);
    step();
    chk("race_all_idle", all_idle, 1'b1);
    chk("race_no_tout_late", tout_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
